yuv_rd_fetch: RTL and testbench
===============================

Name: yuv_rd_fetch

Overview:
- Downstream consumer of the dispatch stage's YUV read request (rd_yuv_start, rd_yuv_addr).
- On each request, issues one AXI4 INCR read burst to DDR and buffers the returned words.
- Serializes the buffered words into the 8-bit rd_yuv_data / rd_yuv_data_vld byte stream that the dispatch stage consumes.
- Read-only AXI4 master; the write channels are not part of this block.

Parameters:
- C_M_AXI_ADDR_WIDTH, 64, AXI address width; araddr = zero-extended 32-bit byte address.
- C_M_AXI_DATA_WIDTH, 32, AXI data width; must be 32, 64 or 128.
- C_M_AXI_ID_WIDTH, 1, AXI ID width; arid is driven as 0.
- BURST_BYTES, 64, bytes fetched per request; power of two, ≥ DATA_WIDTH/8, ≤ 4096.

Ports:
- ap_clk  in  1  system clock
- ap_rst  in  1  asynchronous active-high reset
- rd_yuv_start  in  1  request; level pulse, 2 cycles wide from the dispatch stage
- rd_yuv_addr  in  32  byte address; valid on the start rising edge
- rd_yuv_data_vld  out  1  byte valid
- rd_yuv_data  out  8  byte data
- busy  out  1  request in progress
- rd_err  out  1  sticky: non-OKAY rresp seen
- m_axi_araddr  out  ADDR_WIDTH  read address
- m_axi_arlen  out  8  BURST_BYTES/(DATA_WIDTH/8)-1
- m_axi_arsize  out  3  log2(DATA_WIDTH/8)
- m_axi_arburst  out  2  2'b01 (INCR)
- m_axi_arcache  out  4  4'b0011
- m_axi_arprot  out  3  3'b000
- m_axi_arqos  out  4  4'b0000
- m_axi_arid  out  ID_WIDTH  0
- m_axi_arvalid  out  1
- m_axi_arready  in  1
- m_axi_rdata  in  DATA_WIDTH
- m_axi_rresp  in  2
- m_axi_rlast  in  1
- m_axi_rvalid  in  1
- m_axi_rready  out  1

Behaviour:
- Reset (async, active-high) clears all of the following:
  - Outputs: arvalid, rready, rd_yuv_data_vld, busy, rd_err are 0; rd_yuv_data is 0; araddr is 0.
  - State: FSM returns to IDLE; FIFO is emptied; byte counter is cleared.
- Reset mid-burst: any outstanding AXI transfer is abandoned. The interconnect shares the same reset.
- Request detect: start_rise = rd_yuv_start & ~start_d, where start_d is registered. Only the rising edge counts; the second cycle of the 2-cycle pulse is ignored.
- Address capture: on start_rise in IDLE, rd_yuv_addr is latched and aligned down to BURST_BYTES (low log2(BURST_BYTES) bits cleared). Consequently no burst crosses a 4 KB boundary.
- start_rise while busy=1: ignored. No queueing, no error flag.
- FSM states:
  - IDLE: on start_rise -> AR; busy=1 and arvalid=1 in the next cycle (latency 1 cycle from the rising edge).
  - AR: arvalid held with stable araddr/arlen until arready. On arvalid&arready -> RD; arvalid=0 the following cycle.
  - RD: rready = ~fifo_full. Each rvalid&rready pushes rdata into the FIFO. rresp≠0 sets rd_err (sticky until reset), and the data is still delivered. The rlast beat -> DRAIN. rlast arriving early or late is not checked; the FSM follows rlast.
  - DRAIN: waits until the FIFO is empty and the serializer has emitted its last byte, then -> IDLE. busy drops in the same cycle as the final rd_yuv_data_vld.
- FIFO: synchronous, width DATA_WIDTH, depth = beats per burst (minimum 2). A push and a pop in the same cycle are both allowed, and the count is unchanged. Full blocks rready; empty stalls the serializer.
- Serializer:
  - Pops a word whenever its shift register is empty (or on the last byte) and the FIFO is not empty.
  - Emits one byte per cycle, little-endian: bits [7:0] first.
  - Back-to-back words produce no bubble.
  - Output is registered: the first byte appears 2 cycles after the first FIFO push.
- rd_yuv_data_vld has no backpressure. The consumer accepts every byte.
- Exactly BURST_BYTES valid bytes per accepted request.

Decomposition:
- Package yuv_rd_pkg:
  - AXI constants: BURST_INCR, CACHE_DEFAULT, RESP_OKAY.
  - FSM state encoding: IDLE, AR, RD, DRAIN.
  - Helper functions: log2 for arsize, and beats-per-burst.
- Sub-module yuv_rd_fifo: parameterized sync FIFO with width, depth, full, empty, and async active-high reset.
- FSM and serializer live in the top level.

Test Plan:
- Basic request: start pulse with addr 0x1000_0000, rdata beats 0x03020100, 0x07060504, … → araddr=0x1000_0000, arlen=15, arsize=2; 64 bytes out as 0x00..0x3F in order; busy falls with the 64th byte.
- Alignment and backpressure: addr 0x1000_0023 → araddr=0x1000_0000. With arready held low 5 cycles, arvalid and araddr stay stable and no byte is emitted before the handshake.
- Bursty R channel: rvalid gaps of 3 random cycles → no byte lost or duplicated; the output stream still equals 0x00..0x3F.
- Second start during busy: a second pulse mid-RD → exactly one AR handshake and exactly 64 bytes; a fresh pulse after busy=0 triggers a new burst.
- Error response: rresp=2'b10 on beat 4 → rd_err rises and stays 1; all 64 bytes are still delivered.
- Reset mid-burst: ap_rst asserted after beat 6 → outputs clear immediately. A new request at 0x2000_0040 after release yields a clean 64-byte stream.

Source files
------------

// File: rtl/yuv_rd_pkg.sv
// yuv_rd_pkg: shared constants, FSM encoding and sizing helpers for the
// YUV read-fetch block (yuv_rd_fetch and its FIFO).
package yuv_rd_pkg;

  localparam logic [1:0] BURST_INCR    = 2'b01;
  localparam logic [3:0] CACHE_DEFAULT = 4'b0011;
  localparam logic [2:0] PROT_DEFAULT  = 3'b000;
  localparam logic [3:0] QOS_DEFAULT   = 4'b0000;
  localparam logic [1:0] RESP_OKAY     = 2'b00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    AR    = 2'd1,
    RD    = 2'd2,
    DRAIN = 2'd3
  } rd_state_t;

  // Ceiling log2; used for arsize and counter widths.
  function automatic int log2_fn(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int beats_per_burst(input int burst_bytes, input int data_width);
    return burst_bytes / (data_width / 8);
  endfunction

endpackage

// File: rtl/yuv_rd_fifo.sv
// yuv_rd_fifo: synchronous FIFO with show-ahead read data.
// Ports:
//   ap_clk, ap_rst   clock, async active-high reset (empties the FIFO)
//   push, wdata      write strobe / data (ignored when full)
//   pop, rdata       read strobe / head-of-queue data (ignored when empty)
//   full, empty      occupancy flags
module yuv_rd_fifo
  import yuv_rd_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic             ap_clk,
  input  logic             ap_rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? log2_fn(DEPTH) : 1;
  localparam int CNT_W = log2_fn(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge ap_clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/yuv_rd_fetch.sv
// yuv_rd_fetch: on each rising edge of rd_yuv_start, fetch one aligned
// BURST_BYTES block from DDR with a single AXI4 INCR read burst and replay it
// as a little-endian byte stream on rd_yuv_data / rd_yuv_data_vld.
// Ports:
//   ap_clk, ap_rst                 clock, async active-high reset
//   rd_yuv_start, rd_yuv_addr      request pulse and byte address
//   rd_yuv_data_vld, rd_yuv_data   output byte stream (no backpressure)
//   busy                           request in progress
//   rd_err                         sticky non-OKAY read response
//   m_axi_ar*, m_axi_r*            AXI4 read address / read data channels
//
// state | meaning
// IDLE  | waiting for a start rising edge
// AR    | arvalid asserted, waiting for arready
// RD    | accepting read beats into the FIFO until rlast
// DRAIN | serializer emptying FIFO; leaves on the final byte
module yuv_rd_fetch
  import yuv_rd_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ID_WIDTH   = 1,
  parameter int BURST_BYTES        = 64
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst,
  input  logic                          rd_yuv_start,
  input  logic [31:0]                   rd_yuv_addr,
  output logic                          rd_yuv_data_vld,
  output logic [7:0]                    rd_yuv_data,
  output logic                          busy,
  output logic                          rd_err,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]                    m_axi_arlen,
  output logic [2:0]                    m_axi_arsize,
  output logic [1:0]                    m_axi_arburst,
  output logic [3:0]                    m_axi_arcache,
  output logic [2:0]                    m_axi_arprot,
  output logic [3:0]                    m_axi_arqos,
  output logic [C_M_AXI_ID_WIDTH-1:0]   m_axi_arid,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rlast,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready
);

  localparam int BYTES_PER_BEAT = C_M_AXI_DATA_WIDTH / 8;
  localparam int BEATS          = beats_per_burst(BURST_BYTES, C_M_AXI_DATA_WIDTH);
  localparam int FIFO_DEPTH     = (BEATS < 2) ? 2 : BEATS;
  localparam int SH_CNT_W       = log2_fn(BYTES_PER_BEAT + 1);
  localparam logic [31:0] ALIGN_MASK = ~(32'(BURST_BYTES) - 32'd1);

  rd_state_t state_q;
  rd_state_t state_d;

  logic                          start_d;
  logic                          start_rise;
  logic [C_M_AXI_ADDR_WIDTH-1:0] araddr_q;
  logic                          r_push;
  logic                          fifo_full;
  logic                          fifo_empty;
  logic [C_M_AXI_DATA_WIDTH-1:0] fifo_rdata;
  logic                          ser_pop;
  logic [C_M_AXI_DATA_WIDTH-1:0] sh_data;
  logic [SH_CNT_W-1:0]           sh_cnt;
  logic                          ser_last;

  assign start_rise = rd_yuv_start & ~start_d;
  assign r_push     = m_axi_rvalid & m_axi_rready;

  // sh_cnt counts bytes still held in the shift register. Reloading while the
  // last byte goes out keeps consecutive words gap-free.
  assign ser_pop  = (sh_cnt <= SH_CNT_W'(1)) & ~fifo_empty;
  assign ser_last = (sh_cnt <= SH_CNT_W'(1)) & fifo_empty;

  assign m_axi_araddr  = araddr_q;
  assign m_axi_arlen   = 8'(BEATS - 1);
  assign m_axi_arsize  = 3'(log2_fn(BYTES_PER_BEAT));
  assign m_axi_arburst = BURST_INCR;
  assign m_axi_arcache = CACHE_DEFAULT;
  assign m_axi_arprot  = PROT_DEFAULT;
  assign m_axi_arqos   = QOS_DEFAULT;
  assign m_axi_arid    = '0;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_rise) state_d = AR;
      AR:      if (m_axi_arready) state_d = RD;
      RD:      if (r_push && m_axi_rlast) state_d = DRAIN;
      DRAIN:   if (ser_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m_axi_arvalid = (state_q == AR);
    m_axi_rready  = (state_q == RD) & ~fifo_full;
    busy          = (state_q != IDLE);
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      start_d  <= 1'b0;
      araddr_q <= '0;
      rd_err   <= 1'b0;
    end else begin
      start_d <= rd_yuv_start;
      // Aligning down to the burst size keeps every burst inside one 4 KB page.
      if (state_q == IDLE && start_rise) begin
        araddr_q <= C_M_AXI_ADDR_WIDTH'(rd_yuv_addr & ALIGN_MASK);
      end
      if (r_push && m_axi_rresp != RESP_OKAY) rd_err <= 1'b1;
    end
  end

  yuv_rd_fifo #(
    .WIDTH (C_M_AXI_DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .push   (r_push),
    .wdata  (m_axi_rdata),
    .pop    (ser_pop),
    .rdata  (fifo_rdata),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      sh_data         <= '0;
      sh_cnt          <= '0;
      rd_yuv_data     <= '0;
      rd_yuv_data_vld <= 1'b0;
    end else begin
      if (sh_cnt != '0) begin
        rd_yuv_data     <= sh_data[7:0];
        rd_yuv_data_vld <= 1'b1;
      end else begin
        rd_yuv_data_vld <= 1'b0;
      end
      if (ser_pop) begin
        sh_data <= fifo_rdata;
        sh_cnt  <= SH_CNT_W'(BYTES_PER_BEAT);
      end else if (sh_cnt != '0) begin
        sh_data <= sh_data >> 8;
        sh_cnt  <= sh_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_yuv_rd_fetch.sv
module tb_yuv_rd_fetch;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic        rd_yuv_start;
  logic [31:0] rd_yuv_addr;
  logic        rd_yuv_data_vld;
  logic [7:0]  rd_yuv_data;
  logic        busy;
  logic        rd_err;
  logic [63:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic [3:0]  m_axi_arcache;
  logic [2:0]  m_axi_arprot;
  logic [3:0]  m_axi_arqos;
  logic [0:0]  m_axi_arid;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast;
  logic        m_axi_rvalid;
  logic        m_axi_rready;

  int checks   = 0;
  int errors   = 0;
  int byte_cnt = 0;
  int ar_cnt   = 0;
  logic [7:0] exp_q [$];

  yuv_rd_fetch dut (
    .ap_clk          (ap_clk),
    .ap_rst          (ap_rst),
    .rd_yuv_start    (rd_yuv_start),
    .rd_yuv_addr     (rd_yuv_addr),
    .rd_yuv_data_vld (rd_yuv_data_vld),
    .rd_yuv_data     (rd_yuv_data),
    .busy            (busy),
    .rd_err          (rd_err),
    .m_axi_araddr    (m_axi_araddr),
    .m_axi_arlen     (m_axi_arlen),
    .m_axi_arsize    (m_axi_arsize),
    .m_axi_arburst   (m_axi_arburst),
    .m_axi_arcache   (m_axi_arcache),
    .m_axi_arprot    (m_axi_arprot),
    .m_axi_arqos     (m_axi_arqos),
    .m_axi_arid      (m_axi_arid),
    .m_axi_arvalid   (m_axi_arvalid),
    .m_axi_arready   (m_axi_arready),
    .m_axi_rdata     (m_axi_rdata),
    .m_axi_rresp     (m_axi_rresp),
    .m_axi_rlast     (m_axi_rlast),
    .m_axi_rvalid    (m_axi_rvalid),
    .m_axi_rready    (m_axi_rready)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Output monitor: every emitted byte must match the head of the scoreboard.
  always @(negedge ap_clk) begin
    if (!ap_rst && rd_yuv_data_vld) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_byte actual=%0h required=none", rd_yuv_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (rd_yuv_data !== e) begin
          errors++;
          $display("FAIL byte_stream actual=%0h required=%0h", rd_yuv_data, e);
        end
      end
      byte_cnt++;
    end
  end

  always @(posedge ap_clk) begin
    if (!ap_rst && m_axi_arvalid && m_axi_arready) ar_cnt++;
  end

  task automatic pulse_start(input logic [31:0] a, input bit expect_accept);
    @(posedge ap_clk);
    #1 rd_yuv_start = 1'b1;
    rd_yuv_addr = a;
    @(posedge ap_clk);
    @(negedge ap_clk);
    if (expect_accept) begin
      chk("busy_latency", busy, 1);
      chk("arvalid_latency", m_axi_arvalid, 1);
    end
    @(posedge ap_clk);
    #1 rd_yuv_start = 1'b0;
  endtask

  task automatic ar_handshake(input logic [63:0] exp_addr, input int stall);
    int n;
    int c0;
    n = 0;
    @(negedge ap_clk);
    while (!m_axi_arvalid && n < 100) begin
      @(negedge ap_clk);
      n++;
    end
    chk("arvalid_seen", m_axi_arvalid, 1);
    chk("araddr", m_axi_araddr, exp_addr);
    chk("arlen", m_axi_arlen, 15);
    chk("arsize", m_axi_arsize, 2);
    chk("arburst", m_axi_arburst, 1);
    chk("arcache", m_axi_arcache, 3);
    c0 = byte_cnt;
    for (int i = 0; i < stall; i++) begin
      @(negedge ap_clk);
      chk("arvalid_hold", m_axi_arvalid, 1);
      chk("araddr_hold", m_axi_araddr, exp_addr);
      chk("rready_before_ar", m_axi_rready, 0);
    end
    if (stall > 0) chk("no_byte_before_ar", byte_cnt - c0, 0);
    m_axi_arready = 1'b1;
    @(posedge ap_clk);
    #1 m_axi_arready = 1'b0;
    @(negedge ap_clk);
    chk("arvalid_drop", m_axi_arvalid, 0);
  endtask

  // Called on a negedge; leaves on a negedge.
  task automatic r_burst(input int n_beats, input logic [7:0] base, input int max_gap,
                         input int err_beat);
    for (int b = 0; b < n_beats; b++) begin
      int gap;
      int n;
      logic [31:0] w;
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      if (gap > 0) begin
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        repeat (gap) @(negedge ap_clk);
      end
      for (int i = 0; i < 4; i++) begin
        w[8*i +: 8] = 8'(base + 8'(4*b + i));
        exp_q.push_back(w[8*i +: 8]);
      end
      m_axi_rdata  = w;
      m_axi_rresp  = (b == err_beat) ? 2'b10 : 2'b00;
      m_axi_rlast  = (b == 15);
      m_axi_rvalid = 1'b1;
      n = 0;
      while (!m_axi_rready && n < 100) begin
        @(negedge ap_clk);
        n++;
      end
      if (n >= 100) chk("rready_timeout", m_axi_rready, 1);
      @(posedge ap_clk);
      @(negedge ap_clk);
    end
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
    m_axi_rresp  = 2'b00;
  endtask

  task automatic wait_idle(input int c0);
    int n;
    n = 0;
    while (busy && n < 1000) begin
      @(negedge ap_clk);
      n++;
    end
    chk("busy_fall", busy, 0);
    chk("last_byte_with_busy_fall", rd_yuv_data_vld, 1);
    #1;
    chk("byte_count", byte_cnt - c0, 64);
    chk("scoreboard_empty", exp_q.size(), 0);
  endtask

  task automatic basic_req(input logic [31:0] a, input logic [63:0] exp_a, input int stall,
                           input logic [7:0] base, input int max_gap, input int err_beat);
    int c0;
    c0 = byte_cnt;
    pulse_start(a, 1'b1);
    ar_handshake(exp_a, stall);
    r_burst(16, base, max_gap, err_beat);
    wait_idle(c0);
  endtask

  initial begin
    int c0;
    int a0;
    ap_rst        = 1'b1;
    rd_yuv_start  = 1'b0;
    rd_yuv_addr   = '0;
    m_axi_arready = 1'b0;
    m_axi_rdata   = '0;
    m_axi_rresp   = 2'b00;
    m_axi_rlast   = 1'b0;
    m_axi_rvalid  = 1'b0;
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    chk("rst_busy", busy, 0);
    chk("rst_arvalid", m_axi_arvalid, 0);
    chk("rst_rready", m_axi_rready, 0);
    chk("rst_vld", rd_yuv_data_vld, 0);
    chk("rst_data", rd_yuv_data, 0);
    chk("rst_err", rd_err, 0);
    chk("rst_araddr", m_axi_araddr, 0);
    @(posedge ap_clk);
    #1 ap_rst = 1'b0;
    repeat (2) @(posedge ap_clk);

    // Basic request
    basic_req(32'h1000_0000, 64'h1000_0000, 0, 8'h00, 0, -1);

    // Misaligned address with AR backpressure
    basic_req(32'h1000_0023, 64'h1000_0000, 5, 8'h00, 0, -1);

    // Bursty R channel
    basic_req(32'h1000_0000, 64'h1000_0000, 0, 8'h00, 3, -1);

    // Second start while busy is dropped
    c0 = byte_cnt;
    a0 = ar_cnt;
    pulse_start(32'h1000_0000, 1'b1);
    fork
      begin
        ar_handshake(64'h1000_0000, 0);
        r_burst(16, 8'h00, 3, -1);
      end
      begin
        repeat (8) @(posedge ap_clk);
        chk("busy_mid_rd", busy, 1);
        pulse_start(32'h3000_0000, 1'b0);
      end
    join
    wait_idle(c0);
    repeat (10) @(negedge ap_clk);
    chk("single_ar", ar_cnt - a0, 1);
    chk("no_queued_req", busy, 0);
    chk("no_extra_bytes", byte_cnt - c0, 64);
    a0 = ar_cnt;
    basic_req(32'h1000_0100, 64'h1000_0100, 0, 8'h40, 0, -1);
    chk("fresh_ar", ar_cnt - a0, 1);

    // Error response on beat 4
    chk("err_before", rd_err, 0);
    basic_req(32'h1000_0000, 64'h1000_0000, 0, 8'h00, 0, 4);
    chk("err_set", rd_err, 1);
    repeat (5) @(negedge ap_clk);
    chk("err_sticky", rd_err, 1);

    // Reset mid-burst
    pulse_start(32'h1000_0000, 1'b1);
    ar_handshake(64'h1000_0000, 0);
    r_burst(6, 8'h00, 0, -1);
    #1;
    exp_q.delete();
    ap_rst = 1'b1;
    #1;
    chk("mid_rst_vld", rd_yuv_data_vld, 0);
    chk("mid_rst_data", rd_yuv_data, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_arvalid", m_axi_arvalid, 0);
    chk("mid_rst_rready", m_axi_rready, 0);
    chk("mid_rst_err", rd_err, 0);
    chk("mid_rst_araddr", m_axi_araddr, 0);
    repeat (3) @(posedge ap_clk);
    #1 ap_rst = 1'b0;
    repeat (2) @(posedge ap_clk);
    basic_req(32'h2000_0040, 64'h2000_0040, 0, 8'h80, 0, -1);
    chk("err_after_clean", rd_err, 0);

    repeat (5) @(posedge ap_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

endmodule
